// File: rtl/phase_sample_averager.sv
// Block averager for phase-detector words: collects 2**LOG2_SAMPLES samples and presents
// their truncated mean, minimum and maximum, holding the result until the consumer takes it.
module phase_sample_averager #(
    parameter int DATA_WIDTH   = 16,
    parameter int LOG2_SAMPLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] avg_out,
    output logic [DATA_WIDTH-1:0] min_out,
    output logic [DATA_WIDTH-1:0] max_out,
    output logic                  result_valid,
    output logic [7:0]            dropped_count
);

    localparam int SUM_W = DATA_WIDTH + LOG2_SAMPLES;
    localparam logic [LOG2_SAMPLES-1:0] LAST_IDX = '1;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                  r_state, w_state_next;
    logic [SUM_W-1:0]        r_sum, w_sum_next, w_sum_add;
    logic [LOG2_SAMPLES-1:0] r_count, w_count_next;
    logic [DATA_WIDTH-1:0]   r_min, r_max, w_min_next, w_max_next, w_min_upd, w_max_upd;
    logic [DATA_WIDTH-1:0]   r_avg_out, r_min_out, r_max_out;
    logic [DATA_WIDTH-1:0]   w_avg_out_next, w_min_out_next, w_max_out_next;
    logic                    r_result_valid, w_result_valid_next;
    logic [7:0]              r_dropped, w_dropped_next;

    // A count of zero marks the first sample of a block, which seeds both min and max.
    assign w_sum_add = r_sum + SUM_W'(data_in);
    assign w_min_upd = (r_count == '0 || data_in < r_min) ? data_in : r_min;
    assign w_max_upd = (r_count == '0 || data_in > r_max) ? data_in : r_max;

    // NOTE: every signal gets a default before the branches so no latch is inferred.
    always_comb begin
        w_state_next        = r_state;
        w_sum_next          = r_sum;
        w_count_next        = r_count;
        w_min_next          = r_min;
        w_max_next          = r_max;
        w_avg_out_next      = r_avg_out;
        w_min_out_next      = r_min_out;
        w_max_out_next      = r_max_out;
        w_result_valid_next = r_result_valid;
        w_dropped_next      = r_dropped;

        if (clear) begin
            w_state_next        = ACCUM;
            w_sum_next          = '0;
            w_count_next        = '0;
            w_min_next          = '0;
            w_max_next          = '0;
            w_avg_out_next      = '0;
            w_min_out_next      = '0;
            w_max_out_next      = '0;
            w_result_valid_next = 1'b0;
            w_dropped_next      = '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (data_in_valid) begin
                        w_sum_next   = w_sum_add;
                        w_count_next = r_count + LOG2_SAMPLES'(1);
                        w_min_next   = w_min_upd;
                        w_max_next   = w_max_upd;
                        if (r_count == LAST_IDX) begin
                            w_avg_out_next      = w_sum_add[SUM_W-1:LOG2_SAMPLES];
                            w_min_out_next      = w_min_upd;
                            w_max_out_next      = w_max_upd;
                            w_result_valid_next = 1'b1;
                            w_state_next        = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (data_in_valid && r_dropped != 8'hFF) begin
                        w_dropped_next = r_dropped + 8'd1;
                    end
                    if (out_ready) begin
                        w_result_valid_next = 1'b0;
                        w_state_next        = ACCUM;
                        w_sum_next          = '0;
                        w_count_next        = '0;
                        w_min_next          = '0;
                        w_max_next          = '0;
                    end
                end
                default: w_state_next = ACCUM;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ACCUM;
            r_sum          <= '0;
            r_count        <= '0;
            r_min          <= '0;
            r_max          <= '0;
            r_avg_out      <= '0;
            r_min_out      <= '0;
            r_max_out      <= '0;
            r_result_valid <= 1'b0;
            r_dropped      <= '0;
        end else begin
            r_state        <= w_state_next;
            r_sum          <= w_sum_next;
            r_count        <= w_count_next;
            r_min          <= w_min_next;
            r_max          <= w_max_next;
            r_avg_out      <= w_avg_out_next;
            r_min_out      <= w_min_out_next;
            r_max_out      <= w_max_out_next;
            r_result_valid <= w_result_valid_next;
            r_dropped      <= w_dropped_next;
        end
    end

    assign avg_out       = r_avg_out;
    assign min_out       = r_min_out;
    assign max_out       = r_max_out;
    assign result_valid  = r_result_valid;
    assign dropped_count = r_dropped;

endmodule

// File: tb/tb_phase_sample_averager.sv
// Scoreboard bench for phase_sample_averager: a behavioural block model queues expected
// results as samples are driven; a negedge monitor pops and compares them as results appear.
module tb_phase_sample_averager;

    typedef struct packed {
        logic [15:0] avg;
        logic [15:0] min;
        logic [15:0] max;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] avg_out, min_out, max_out;
    logic        result_valid;
    logic [7:0]  dropped_count;

    int n_checks = 0;
    int n_errors = 0;

    res_t exp_q[$];
    res_t held;
    logic rv_q = 1'b0;

    // Behavioural model of the block protocol, advanced once per driven cycle.
    int          m_sum = 0;
    int          m_cnt = 0;
    int          m_dropped = 0;
    logic [15:0] m_min = '0;
    logic [15:0] m_max = '0;
    bit          m_hold = 1'b0;

    phase_sample_averager #(.DATA_WIDTH(16), .LOG2_SAMPLES(2)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .data_in(data_in), .data_in_valid(data_in_valid), .out_ready(out_ready),
        .avg_out(avg_out), .min_out(min_out), .max_out(max_out),
        .result_valid(result_valid), .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            rv_q = 1'b0;
        end else begin
            if (result_valid && !rv_q) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_result: got avg=%0d min=%0d max=%0d, required no result",
                             avg_out, min_out, max_out);
                end else begin
                    held = exp_q.pop_front();
                    if ({avg_out, min_out, max_out} !== held) begin
                        n_errors++;
                        $display("FAIL result: got avg=%0d min=%0d max=%0d, required avg=%0d min=%0d max=%0d",
                                 avg_out, min_out, max_out, held.avg, held.min, held.max);
                    end
                end
            end else if (result_valid) begin
                n_checks++;
                if ({avg_out, min_out, max_out} !== held) begin
                    n_errors++;
                    $display("FAIL hold_stable: got avg=%0d min=%0d max=%0d, required avg=%0d min=%0d max=%0d",
                             avg_out, min_out, max_out, held.avg, held.min, held.max);
                end
            end
            rv_q = result_valid;
        end
    end

    task automatic model_reset();
        m_sum = 0; m_cnt = 0; m_dropped = 0; m_hold = 1'b0;
    endtask

    // Applies inputs for one clock, updates the model and returns 1 time unit after the edge.
    task automatic drive(input logic v, input logic [15:0] d, input logic rdy, input logic clr);
        res_t r;
        data_in_valid = v; data_in = d; out_ready = rdy; clear = clr;
        if (clr) begin
            model_reset();
        end else if (!m_hold) begin
            if (v) begin
                m_sum += int'(d);
                if (m_cnt == 0) begin
                    m_min = d; m_max = d;
                end else begin
                    if (d < m_min) m_min = d;
                    if (d > m_max) m_max = d;
                end
                m_cnt++;
                if (m_cnt == 4) begin
                    r.avg = 16'(m_sum / 4);
                    r.min = m_min;
                    r.max = m_max;
                    exp_q.push_back(r);
                    m_hold = 1'b1;
                    m_cnt = 0;
                    m_sum = 0;
                end
            end
        end else begin
            if (v && m_dropped < 255) m_dropped++;
            if (rdy) m_hold = 1'b0;
        end
        @(posedge clk);
        #1;
        data_in_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({avg_out, min_out, max_out, result_valid, dropped_count} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got avg=%0d min=%0d max=%0d rv=%b drop=%0d, required all 0",
                     avg_out, min_out, max_out, result_valid, dropped_count);
        end
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        drive(1, 16'd10, 1, 0);
        drive(1, 16'd20, 1, 0);
        drive(1, 16'd30, 1, 0);
        n_checks++;
        if (result_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_early_valid: got %b, required 0", result_valid);
        end
        drive(1, 16'd40, 1, 0);
        n_checks++;
        if (result_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_valid_rise: got %b, required 1", result_valid);
        end
        drive(0, 16'd0, 1, 0);
        n_checks++;
        if (result_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_valid_one_cycle: got %b, required 0", result_valid);
        end
    endtask

    task automatic test_full_scale();
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'hFFFF, 1, 0);
            drive(0, 16'h0000, 1, 0);
        end
        n_checks++;
        if (avg_out !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL full_scale_avg: got %h, required ffff", avg_out);
        end
    endtask

    task automatic test_backpressure();
        drive(1, 16'd7, 0, 0);
        drive(1, 16'd3, 0, 0);
        drive(1, 16'd9, 0, 0);
        drive(1, 16'd5, 0, 0);
        for (int i = 0; i < 5; i++) drive(((i % 2) == 0), 16'(100 + i), 0, 0);
        n_checks++;
        if (dropped_count !== 8'd3 || result_valid !== 1'b1 || avg_out !== 16'd6 ||
            min_out !== 16'd3 || max_out !== 16'd9) begin
            n_errors++;
            $display("FAIL backpressure_hold: got drop=%0d rv=%b avg=%0d min=%0d max=%0d, required 3 1 6 3 9",
                     dropped_count, result_valid, avg_out, min_out, max_out);
        end
        drive(0, 16'd0, 1, 0);
        n_checks++;
        if (result_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL backpressure_release: got rv=%b, required 0", result_valid);
        end
        drive(1, 16'd1, 0, 0);
        drive(1, 16'd2, 0, 0);
        drive(1, 16'd3, 0, 0);
        drive(1, 16'd4, 0, 0);
        drive(0, 16'd0, 1, 0);
        n_checks++;
        if (dropped_count !== 8'd3) begin
            n_errors++;
            $display("FAIL dropped_persist: got %0d, required 3", dropped_count);
        end
    endtask

    task automatic test_reset_midblock();
        drive(1, 16'd100, 0, 0);
        drive(1, 16'd200, 0, 0);
        rst = 1'b1;
        #1;
        n_checks++;
        if (dropped_count !== 8'd0 || result_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got drop=%0d rv=%b, required 0 0", dropped_count, result_valid);
        end
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        drive(1, 16'd4, 0, 0);
        drive(1, 16'd4, 0, 0);
        drive(1, 16'd4, 0, 0);
        drive(1, 16'd8, 0, 0);
        drive(0, 16'd0, 1, 0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) drive(1, 16'd1, 0, 0);
        for (int i = 0; i < 300; i++) drive(1, 16'(i), 0, 0);
        n_checks++;
        if (dropped_count !== 8'd255 || result_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL saturation: got drop=%0d rv=%b, required 255 1", dropped_count, result_valid);
        end
        drive(1, 16'd5, 0, 1);
        n_checks++;
        if ({avg_out, min_out, max_out, result_valid, dropped_count} !== '0) begin
            n_errors++;
            $display("FAIL clear_outputs: got avg=%0d min=%0d max=%0d rv=%b drop=%0d, required all 0",
                     avg_out, min_out, max_out, result_valid, dropped_count);
        end
    endtask

    task automatic test_clear_coincident();
        drive(1, 16'd1, 0, 0);
        drive(1, 16'd2, 0, 0);
        drive(1, 16'd3, 0, 0);
        drive(1, 16'd4, 0, 1);
        drive(0, 16'd0, 0, 0);
        n_checks++;
        if (result_valid !== 1'b0 || dropped_count !== 8'd0) begin
            n_errors++;
            $display("FAIL clear_coincident: got rv=%b drop=%0d, required 0 0", result_valid, dropped_count);
        end
        drive(1, 16'd2, 1, 0);
        drive(1, 16'd4, 1, 0);
        drive(1, 16'd6, 1, 0);
        drive(1, 16'd8, 1, 0);
        drive(0, 16'd0, 1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_scale();
        test_backpressure();
        test_reset_midblock();
        test_saturation();
        test_clear_coincident();
        repeat (3) drive(0, 16'd0, 1, 0);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d results outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
